id_operand_stage: RTL
=====================

// Module: id_operand_stage
// PURPOSE
//  Decode-side operand fetch plus ID/EX pipeline register for the RISC-V pipeline.
//  Drives the register-file read addresses from the instruction in ID and captures the read data, PC, instr and rd into ID/EX.
//  Interlocks RAW hazards with a per-register pending-write scoreboard (no forwarding); hands off to EX via valid/ready.
// PARAMETERS
//  DATA_WIDTH     32  register / PC width
//  ADDRESS_WIDTH  5   register index width
//  NUM_REGS       32  architectural registers (2**ADDRESS_WIDTH)
//  CNT_W          2   pending-write counter width per register (max 2**CNT_W-1 in flight)
// PORTS
//  clk          in   1     clock, all state on posedge
//  rst_n        in   1     synchronous reset, active-low
//  if_valid     in   1     IF/ID holds an instruction
//  if_ready     out  1     ID accepts instruction this cycle
//  if_instr     in   32    instruction word
//  if_pc        in   DW    PC of if_instr
//  flush        in   1     kill ID and ID/EX contents (branch/jump redirect from EX)
//  rf_rd_addr1  out  AW    = if_instr[19:15] (combinational)
//  rf_rd_addr2  out  AW    = if_instr[24:20] (combinational)
//  rf_rd_data1  in   DW    register-file read data 1
//  rf_rd_data2  in   DW    register-file read data 2
//  wb_wrt_en    in   1     writeback commit (same net as register-file write enable)
//  wb_wrt_dest  in   AW    writeback destination
//  ex_valid     out  1     ID/EX entry valid
//  ex_ready     in   1     EX consumes entry this cycle
//  ex_instr     out  32    registered instruction
//  ex_pc        out  DW    registered PC
//  ex_rs1_data  out  DW    registered operand 1 (0 when rs1==x0)
//  ex_rs2_data  out  DW    registered operand 2 (0 when rs2==x0)
//  ex_rd        out  AW    registered destination (0 if instr writes no rd)
// BEHAVIOUR
//  Reset (rst_n==0 at posedge): ex_valid=0, ex_instr=0 (not NOP encoding), ex_pc/ex_rs*_data/ex_rd=0, all scoreboard counters=0;
//   reset mid-operation drops every in-flight entry and pending count.
//  Decode: rs1 used unless opcode LUI/AUIPC/JAL; rs2 used for OP, STORE, BRANCH; rd written unless STORE/BRANCH or rd==0.
//  hazard = (rs1 used & rs1!=0 & (cnt[rs1]!=0 | (ex_valid & ex_rd==rs1)))
//         | (same for rs2) | (rd written & cnt[rd]==max).
//  if_ready = ~hazard & ~flush & (~ex_valid | ex_ready).
//  Capture: if_valid & if_ready -> next cycle ex_valid=1 with fields; latency 1 cycle.
//  Hold: ex_valid & ~ex_ready -> all ex_* stable.
//  Drain: ex_valid & ex_ready & no capture -> ex_valid=0.
//  Flush: priority over capture; next cycle ex_valid=0; flushed entry never counted in scoreboard.
//  Scoreboard inc: on handoff (ex_valid & ex_ready & ex_rd!=0), cnt[ex_rd]+1.
//  Scoreboard dec: on wb_wrt_en & wb_wrt_dest!=0, cnt[wb_wrt_dest]-1, floor 0 (never underflows).
//  Same reg inc and dec in one cycle -> count unchanged. cnt[0] constant 0.
//  Register file writes on negedge: a source freed by a WB in cycle N is read with new data in cycle N+1 (1-cycle bubble).
// STRUCTURE
//  riscv_pkg: opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC), field LSB/MSB constants, decode helper functions.
//  Sub-module id_scoreboard: counter array, inc/dec ports, busy/full query for 3 addresses.
// TESTING
//  reset: rst_n=0 2 cycles with if_valid=1 -> ex_valid=0, if_ready=0 during reset, all cnt=0 afterwards.
//  addi x5,x0,7 then add x6,x5,x5 -> add stalls (if_ready=0) until wb_wrt_en/dest=5, issues next cycle with rs data 7.
//  ex_ready=0 for 3 cycles with ex_valid=1 -> ex_* unchanged, if_ready=0; ex_ready=1 -> next instr captured.
//  flush with if_valid=1 and ex_valid=1 -> next cycle ex_valid=0, no cnt change; instruction reissued afterwards is accepted.
//  3 back-to-back writes to x7 with no WB -> 4th writer to x7 stalls (cnt=3); one WB to x7 releases it.
//  rs1=x0 and wb_wrt_dest=0 with wb_wrt_en=1 -> ex_rs1_data=0, no stall, cnt[0] stays 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants and helpers.
// Used by the ID stage and its operand scoreboard.
package riscv_pkg;

  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 6;
  localparam int RD_LSB  = 7;
  localparam int RD_MSB  = 11;
  localparam int RS1_LSB = 15;
  localparam int RS1_MSB = 19;
  localparam int RS2_LSB = 20;
  localparam int RS2_MSB = 24;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic rs1_used;
    logic rs2_used;
    logic rd_wr;
  } dec_t;

  function automatic dec_t f_decode(
    input logic [6:0] opc,
    input logic       rd_nz
  );
    dec_t d;
    d.rs1_used = 1'b1;
    d.rs2_used = 1'b0;
    d.rd_wr    = rd_nz;
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL:
        d.rs1_used = 1'b0;
      OPC_OP:
        d.rs2_used = 1'b1;
      OPC_STORE, OPC_BRANCH: begin
        d.rs2_used = 1'b1;
        d.rd_wr    = 1'b0;
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/id_scoreboard.sv
// Per-register pending-write counters for the ID interlock.
// Increments on EX handoff, decrements on writeback, floors at 0.
module id_scoreboard
  import riscv_pkg::*;
#(
  parameter int AW    = 5,
  parameter int NREGS = 32,
  parameter int CNT_W = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_inc,
  input  logic [AW-1:0] i_inc_addr,
  input  logic          i_dec,
  input  logic [AW-1:0] i_dec_addr,
  input  logic [AW-1:0] i_q1_addr,
  input  logic [AW-1:0] i_q2_addr,
  input  logic [AW-1:0] i_q3_addr,
  output logic          o_busy1,
  output logic          o_busy2,
  output logic          o_full,
  output logic          o_near_full
);

  localparam logic [CNT_W-1:0] MAX = '1;

  logic [CNT_W-1:0] r_cnt [NREGS];

  // Entry 0 is only ever written by reset, so x0 never looks busy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        r_cnt[i] <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (i_inc && i_inc_addr == AW'(i) &&
            !(i_dec && i_dec_addr == AW'(i)) &&
            r_cnt[i] != MAX)
          r_cnt[i] <= r_cnt[i] + 1'b1;
        else if (i_dec && i_dec_addr == AW'(i) &&
                 !(i_inc && i_inc_addr == AW'(i)) &&
                 r_cnt[i] != '0)
          r_cnt[i] <= r_cnt[i] - 1'b1;
      end
    end
  end

  assign o_busy1     = r_cnt[i_q1_addr] != '0;
  assign o_busy2     = r_cnt[i_q2_addr] != '0;
  assign o_full      = r_cnt[i_q3_addr] == MAX;
  assign o_near_full = r_cnt[i_q3_addr] == MAX - 1'b1;

endmodule

// File: rtl/id_operand_stage.sv
// ID operand fetch, RAW interlock and ID/EX register.
// Hands decoded operands to EX over valid/ready.
module id_operand_stage
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int NUM_REGS      = 32,
  parameter int CNT_W         = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     if_valid,
  output logic                     if_ready,
  input  logic [31:0]              if_instr,
  input  logic [DATA_WIDTH-1:0]    if_pc,
  input  logic                     flush,
  output logic [ADDRESS_WIDTH-1:0] rf_rd_addr1,
  output logic [ADDRESS_WIDTH-1:0] rf_rd_addr2,
  input  logic [DATA_WIDTH-1:0]    rf_rd_data1,
  input  logic [DATA_WIDTH-1:0]    rf_rd_data2,
  input  logic                     wb_wrt_en,
  input  logic [ADDRESS_WIDTH-1:0] wb_wrt_dest,
  output logic                     ex_valid,
  input  logic                     ex_ready,
  output logic [31:0]              ex_instr,
  output logic [DATA_WIDTH-1:0]    ex_pc,
  output logic [DATA_WIDTH-1:0]    ex_rs1_data,
  output logic [DATA_WIDTH-1:0]    ex_rs2_data,
  output logic [ADDRESS_WIDTH-1:0] ex_rd
);

  logic [ADDRESS_WIDTH-1:0] w_rs1, w_rs2, w_rd;
  dec_t w_dec;
  logic w_busy1, w_busy2, w_full, w_near;
  logic w_haz1, w_haz2, w_haz_rd, w_hazard;
  logic w_cap, w_hand;

  logic                     r_valid;
  logic [31:0]              r_instr;
  logic [DATA_WIDTH-1:0]    r_pc;
  logic [DATA_WIDTH-1:0]    r_rs1_data;
  logic [DATA_WIDTH-1:0]    r_rs2_data;
  logic [ADDRESS_WIDTH-1:0] r_rd;

  assign w_rs1 = if_instr[RS1_MSB:RS1_LSB];
  assign w_rs2 = if_instr[RS2_MSB:RS2_LSB];
  assign w_rd  = if_instr[RD_MSB:RD_LSB];
  assign w_dec = f_decode(if_instr[OPC_MSB:OPC_LSB],
                          w_rd != '0);

  assign rf_rd_addr1 = w_rs1;
  assign rf_rd_addr2 = w_rs2;

  id_scoreboard #(
    .AW    (ADDRESS_WIDTH),
    .NREGS (NUM_REGS),
    .CNT_W (CNT_W)
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_inc       (w_hand && r_rd != '0),
    .i_inc_addr  (r_rd),
    .i_dec       (wb_wrt_en && wb_wrt_dest != '0),
    .i_dec_addr  (wb_wrt_dest),
    .i_q1_addr   (w_rs1),
    .i_q2_addr   (w_rs2),
    .i_q3_addr   (w_rd),
    .o_busy1     (w_busy1),
    .o_busy2     (w_busy2),
    .o_full      (w_full),
    .o_near_full (w_near)
  );

  assign w_haz1 = w_dec.rs1_used && w_rs1 != '0 &&
                  (w_busy1 || (r_valid && r_rd == w_rs1));
  assign w_haz2 = w_dec.rs2_used && w_rs2 != '0 &&
                  (w_busy2 || (r_valid && r_rd == w_rs2));
  // The ID/EX writer is not yet counted; include it so the counter never wraps.
  assign w_haz_rd = w_dec.rd_wr &&
                    (w_full ||
                     (w_near && r_valid && r_rd == w_rd));
  assign w_hazard = w_haz1 || w_haz2 || w_haz_rd;

  assign if_ready = rst_n && !w_hazard && !flush &&
                    (!r_valid || ex_ready);
  assign w_cap  = if_valid && if_ready;
  assign w_hand = r_valid && ex_ready && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_instr    <= '0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_rd       <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_cap) begin
      r_valid    <= 1'b1;
      r_instr    <= if_instr;
      r_pc       <= if_pc;
      r_rs1_data <= (w_rs1 == '0) ? '0 : rf_rd_data1;
      r_rs2_data <= (w_rs2 == '0) ? '0 : rf_rd_data2;
      r_rd       <= w_dec.rd_wr ? w_rd : '0;
    end else if (ex_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign ex_valid    = r_valid;
  assign ex_instr    = r_instr;
  assign ex_pc       = r_pc;
  assign ex_rs1_data = r_rs1_data;
  assign ex_rs2_data = r_rs2_data;
  assign ex_rd       = r_rd;

endmodule
